// File: rtl/lsu_mem_if.sv
// Load/store unit between the core's M stage and a word-addressed req/ready data bus.
// Build option LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of aligning them.
module lsu_mem_if #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        lsu_busy,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic [3:0]    bus_be_q, bus_be_d;

  logic          illegal;
  logic          reject;
  logic [1:0]    off_eff;
  logic          timeout_hit;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_ext;

  always_comb begin
    illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) || (req_funct3[2] && req_we);
`ifdef LSU_MISALIGN_TRAP_EN
    off_eff = req_addr[1:0];
    reject  = illegal
           || ((req_funct3[1:0] == 2'b01) && req_addr[0])
           || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    // Misaligned halves/words are silently pulled down to their natural boundary.
    case (req_funct3[1:0])
      2'b01:   off_eff = {req_addr[1], 1'b0};
      2'b10:   off_eff = 2'b00;
      default: off_eff = req_addr[1:0];
    endcase
    reject = illegal;
`endif
  end

  generate
    if (TIMEOUT_CYCLES != 0) begin : g_timeout
      assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    byte_sel = bus_rdata[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    f3_d        = f3_q;
    off_d       = off_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = 1'b0;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    case (state_q)
      IDLE: begin
        if (req_valid && reject) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = DONE;
        end else if (req_valid) begin
          f3_d       = req_funct3;
          off_d      = off_eff;
          cnt_d      = '0;
          bus_req_d  = 1'b1;
          bus_we_d   = req_we;
          bus_addr_d = {req_addr[31:2], 2'b00};
          case (req_funct3[1:0])
            2'b00: begin
              bus_wdata_d = {4{req_wdata[7:0]}};
              bus_be_d    = req_we ? (4'b0001 << off_eff) : 4'b1111;
            end
            2'b01: begin
              bus_wdata_d = {2{req_wdata[15:0]}};
              bus_be_d    = !req_we ? 4'b1111 : (off_eff[1] ? 4'b1100 : 4'b0011);
            end
            default: begin
              bus_wdata_d = req_wdata;
              bus_be_d    = 4'b1111;
            end
          endcase
          state_d = BUS;
        end
      end
      BUS: begin
        cnt_d = cnt_q + CW'(1);
        // A ready arriving on the final allowed cycle still completes cleanly.
        if (bus_ready) begin
          bus_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = bus_we_q ? 32'h0 : load_ext;
          state_d     = DONE;
        end else if (timeout_hit) begin
          bus_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      bus_be_q    <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
    end
  end

  assign lsu_busy  = ((state_q == IDLE) && req_valid) || (state_q == BUS);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_be    = bus_be_q;
endmodule

// File: tb/tb_lsu_mem_if.sv
// Bench for lsu_mem_if: directed vector table, reset/abort sequence, and random accesses vs. a reference model.
// Two instances share the stimulus: one with a 4-cycle timeout, one with the default 255.
module tb_lsu_mem_if;
  localparam int unsigned TO_A = 4;
  localparam int unsigned TO_B = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        sel = 1'b0;

  logic        busy_a, rv_a, err_a, breq_a, bwe_a;
  logic [31:0] rd_a, badr_a, bwd_a;
  logic [3:0]  bbe_a;
  logic        busy_b, rv_b, err_b, breq_b, bwe_b;
  logic [31:0] rd_b, badr_b, bwd_b;
  logic [3:0]  bbe_b;

  logic        lsu_busy, rsp_valid, rsp_err, bus_req, bus_we;
  logic [31:0] rsp_rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lsu_mem_if #(.TIMEOUT_CYCLES(TO_A)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .lsu_busy(busy_a), .rsp_valid(rv_a),
    .rsp_rdata(rd_a), .rsp_err(err_a), .bus_req(breq_a), .bus_we(bwe_a), .bus_addr(badr_a),
    .bus_wdata(bwd_a), .bus_be(bbe_a), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  lsu_mem_if #(.TIMEOUT_CYCLES(TO_B)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .lsu_busy(busy_b), .rsp_valid(rv_b),
    .rsp_rdata(rd_b), .rsp_err(err_b), .bus_req(breq_b), .bus_we(bwe_b), .bus_addr(badr_b),
    .bus_wdata(bwd_b), .bus_be(bbe_b), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  assign lsu_busy  = sel ? busy_b : busy_a;
  assign rsp_valid = sel ? rv_b   : rv_a;
  assign rsp_rdata = sel ? rd_b   : rd_a;
  assign rsp_err   = sel ? err_b  : err_a;
  assign bus_req   = sel ? breq_b : breq_a;
  assign bus_we    = sel ? bwe_b  : bwe_a;
  assign bus_addr  = sel ? badr_b : badr_a;
  assign bus_wdata = sel ? bwd_b  : bwd_a;
  assign bus_be    = sel ? bbe_b  : bbe_a;

  typedef struct {
    logic        bus;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          cycles;
  } exp_t;

  typedef struct {
    logic        s;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    exp_t        e;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(logic s, logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                               logic [31:0] rdata, int waits, logic bus, logic [31:0] eaddr, logic [3:0] ebe,
                               logic [31:0] ewdata, logic [31:0] erdata, logic eerr, int ecyc);
    vec_t v;
    v.s = s; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.waits = waits;
    v.e.bus = bus; v.e.addr = eaddr; v.e.be = ebe; v.e.wdata = ewdata;
    v.e.rdata = erdata; v.e.err = eerr; v.e.cycles = ecyc;
    return v;
  endfunction

  // Reference: access size from funct3, lanes by byte arithmetic on the address offset.
  function automatic exp_t model(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                                 logic [31:0] rdata, int waits, int to);
    exp_t e;
    int sz, a;
    logic [31:0] v;
    e = '{default: 0};
    sz = 1 << f3[1:0];
    a = int'(addr[1:0]);
    if (f3 == 3'd3 || f3 >= 3'd6 || (we && f3[2])) begin
      e.err = 1'b1;
      return e;
    end
`ifdef LSU_MISALIGN_TRAP_EN
    if (a % sz != 0) begin
      e.err = 1'b1;
      return e;
    end
`endif
    a = a - (a % sz);
    e.bus  = 1'b1;
    e.addr = addr & 32'hFFFF_FFFC;
    e.be   = we ? 4'(((1 << sz) - 1) << a) : 4'hF;
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wdata[8*(i % sz) +: 8];
    if (to != 0 && waits >= to) begin
      e.err = 1'b1;
      e.cycles = to;
      return e;
    end
    e.cycles = waits + 1;
    if (!we) begin
      v = rdata >> (8 * a);
      if (sz == 1) begin
        v = v & 32'hFF;
        if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2) begin
        v = v & 32'hFFFF;
        if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
      end
      e.rdata = v;
    end
    return e;
  endfunction

  task automatic run(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rdata, input int waits, input exp_t e);
    logic saw, stable, busy_ok, we0;
    logic [31:0] a0, w0, got_rd;
    logic [3:0] be0;
    logic got_err;
    int nb, n;
    saw = 1'b0; stable = 1'b1; busy_ok = 1'b1; we0 = 1'b0;
    a0 = 32'h0; w0 = 32'h0; be0 = 4'h0; nb = 0; n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    bus_rdata = rdata;
    #1;
    if (!lsu_busy) busy_ok = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = $urandom(); req_wdata = $urandom();
    while (!rsp_valid && n < 64) begin
      if (bus_req) begin
        if (!saw) begin
          saw = 1'b1; a0 = bus_addr; w0 = bus_wdata; be0 = bus_be; we0 = bus_we;
        end else if (bus_addr !== a0 || bus_wdata !== w0 || bus_be !== be0 || bus_we !== we0) begin
          stable = 1'b0;
        end
        if (!lsu_busy) busy_ok = 1'b0;
        bus_ready = (nb == waits);
        nb++;
      end
      @(posedge clk);
      #1;
      bus_ready = 1'b0;
      n++;
    end
    chk({tag, " rsp_valid_seen"}, 32'(rsp_valid), 32'd1);
    got_rd = rsp_rdata; got_err = rsp_err;
    chk({tag, " bus_taken"}, 32'(saw), 32'(e.bus));
    if (e.bus) begin
      chk({tag, " bus_addr"}, a0, e.addr);
      chk({tag, " bus_be"}, 32'(be0), 32'(e.be));
      chk({tag, " bus_we"}, 32'(we0), 32'(we));
      if (we) chk({tag, " bus_wdata"}, w0, e.wdata);
      chk({tag, " bus_stable"}, 32'(stable), 32'd1);
    end
    chk({tag, " bus_cycles"}, 32'(nb), 32'(e.cycles));
    chk({tag, " latency"}, 32'(n), 32'(e.bus ? e.cycles : 0));
    chk({tag, " busy"}, 32'(busy_ok), 32'd1);
    chk({tag, " rsp_rdata"}, got_rd, e.rdata);
    chk({tag, " rsp_err"}, 32'(got_err), 32'(e.err));
    @(posedge clk);
    #1;
    chk({tag, " rsp_pulse_clear"}, 32'(rsp_valid), 32'd0);
    $display("[TB] txn %s we=%0d f3=%0d addr=0x%08h rdata=0x%08h err=%0d bus_cycles=%0d",
             tag, we, f3, addr, got_rd, got_err, nb);
  endtask

  initial begin
    vec_t vt[$];
    exp_t e;
    logic we;
    logic [2:0] f3;
    logic [31:0] addr, wdata, rdata;
    int waits;
    logic quiet;

    vt.push_back(mkv(0, 1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 1, 32'h1000, 4'b1000, 32'hA5A5_A5A5, 32'h0, 0, 1));
    vt.push_back(mkv(0, 0, 3'b000, 32'h0000_2002, 32'h0, 32'h1280_3456, 0, 1, 32'h2000, 4'hF, 32'h0, 32'hFFFF_FF80, 0, 1));
    vt.push_back(mkv(0, 0, 3'b100, 32'h0000_2002, 32'h0, 32'h1280_3456, 0, 1, 32'h2000, 4'hF, 32'h0, 32'h0000_0080, 0, 1));
    vt.push_back(mkv(0, 0, 3'b101, 32'h0000_2002, 32'h0, 32'h1280_3456, 0, 1, 32'h2000, 4'hF, 32'h0, 32'h0000_1280, 0, 1));
    vt.push_back(mkv(0, 0, 3'b001, 32'h0000_2000, 32'h0, 32'h0000_8001, 0, 1, 32'h2000, 4'hF, 32'h0, 32'hFFFF_8001, 0, 1));
    vt.push_back(mkv(1, 0, 3'b010, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, 5, 1, 32'h3000, 4'hF, 32'h0, 32'hDEAD_BEEF, 0, 6));
    vt.push_back(mkv(0, 0, 3'b010, 32'h0000_5000, 32'h0, 32'h1234_5678, 100, 1, 32'h5000, 4'hF, 32'h0, 32'h0, 1, 4));
    vt.push_back(mkv(0, 0, 3'b010, 32'h0000_5004, 32'h0, 32'hCAFE_F00D, 3, 1, 32'h5004, 4'hF, 32'h0, 32'hCAFE_F00D, 0, 4));
    vt.push_back(mkv(0, 0, 3'b011, 32'h0000_0010, 32'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 0));
    vt.push_back(mkv(0, 1, 3'b100, 32'h0000_0010, 32'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 0));
    vt.push_back(mkv(0, 1, 3'b000, 32'h0000_7001, 32'h0000_005A, 32'h0, 0, 1, 32'h7000, 4'b0010, 32'h5A5A_5A5A, 32'h0, 0, 1));
    vt.push_back(mkv(0, 1, 3'b001, 32'h0000_7002, 32'h1234_ABCD, 32'h0, 1, 1, 32'h7000, 4'b1100, 32'hABCD_ABCD, 32'h0, 0, 2));
`ifdef LSU_MISALIGN_TRAP_EN
    vt.push_back(mkv(0, 1, 3'b010, 32'h0000_4002, 32'h1122_3344, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 0));
    vt.push_back(mkv(0, 1, 3'b001, 32'h0000_6003, 32'h0000_BEEF, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 0));
    vt.push_back(mkv(0, 0, 3'b010, 32'h0000_8001, 32'h0, 32'h0102_0304, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 0));
    vt.push_back(mkv(0, 0, 3'b001, 32'h0000_9003, 32'h0, 32'h8001_7FFF, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 0));
`else
    vt.push_back(mkv(0, 1, 3'b010, 32'h0000_4002, 32'h1122_3344, 32'h0, 0, 1, 32'h4000, 4'hF, 32'h1122_3344, 32'h0, 0, 1));
    vt.push_back(mkv(0, 1, 3'b001, 32'h0000_6003, 32'h0000_BEEF, 32'h0, 0, 1, 32'h6000, 4'b1100, 32'hBEEF_BEEF, 32'h0, 0, 1));
    vt.push_back(mkv(0, 0, 3'b010, 32'h0000_8001, 32'h0, 32'h0102_0304, 0, 1, 32'h8000, 4'hF, 32'h0, 32'h0102_0304, 0, 1));
    vt.push_back(mkv(0, 0, 3'b001, 32'h0000_9003, 32'h0, 32'h8001_7FFF, 0, 1, 32'h9000, 4'hF, 32'h0, 32'hFFFF_8001, 0, 1));
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);
    chk("reset bus_req", 32'(bus_req), 32'd0);
    chk("reset bus_fields", {bus_addr[31:8] | bus_wdata[31:8], 3'b000, bus_we, bus_be}, 32'h0);
    chk("reset lsu_busy", 32'(lsu_busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vt[i]) begin
      sel = vt[i].s;
      run($sformatf("vec%0d", i), vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, vt[i].rdata, vt[i].waits, vt[i].e);
    end

    // Reset while the bus access is outstanding
    sel = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_3000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("midop bus_req_before", 32'(bus_req), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midop bus_req", 32'(bus_req), 32'd0);
    chk("midop rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midop lsu_busy", 32'(lsu_busy), 32'd0);
    chk("midop bus_addr", bus_addr, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    quiet = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (rsp_valid || bus_req) quiet = 1'b0;
    end
    chk("midop no_response", 32'(quiet), 32'd1);
    run("post_reset_lw", 1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'h5555_AAAA, 1,
        model(1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'h5555_AAAA, 1, TO_A));
    run("post_reset_illegal", 1'b0, 3'b011, 32'h0000_3000, 32'h0, 32'h0, 0,
        model(1'b0, 3'b011, 32'h0000_3000, 32'h0, 32'h0, 0, TO_A));

    for (int k = 0; k < 150; k++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      addr = $urandom();
      wdata = $urandom();
      rdata = $urandom();
      waits = $urandom_range(0, 5);
      e = model(we, f3, addr, wdata, rdata, waits, TO_A);
      run($sformatf("rnd%0d", k), we, f3, addr, wdata, rdata, waits, e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Load/store unit directly downstream of the pipelined core's M stage.
- Consumes the M-stage data address, store data, write flag and funct3. Drives a word-addressed data memory bus with a req/ready handshake.
- Returns byte/halfword-aligned, sign- or zero-extended load data for the writeback mux.
- Stalls the pipeline while a bus transaction is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, number of BUS-state cycles without bus_ready before the access is aborted; 0 disables the timeout.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-low reset
req_valid  input  1  M-stage holds a load/store this cycle
req_we  input  1  1=store, 0=load
req_funct3  input  3  RISC-V funct3 of the load/store
req_addr  input  32  byte address (core daddr)
req_wdata  input  32  store data (core data_out)
lsu_busy  output  1  pipeline stall request; combinational
rsp_valid  output  1  one-cycle pulse: access complete
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_err  output  1  valid with rsp_valid: illegal funct3, timeout, or misalignment (see macro)
bus_req  output  1  bus request, held until accepted
bus_we  output  1  bus write
bus_addr  output  32  word address: {addr[31:2],2'b00}
bus_wdata  output  32  lane-replicated store data
bus_be  output  4  byte enables (bit i = byte lane i)
bus_ready  input  1  slave accepts or completes the request this cycle
bus_rdata  input  32  read word, valid when bus_ready=1 on a read

Behaviour:
- Reset (rst==0 at clock edge): state=IDLE, timeout counter=0. All registered outputs are 0: rsp_valid, rsp_rdata, rsp_err, bus_req, bus_we, bus_addr, bus_wdata, bus_be.
- Reset mid-transaction aborts the access: bus_req falls at that edge and no rsp_valid is produced.
- FSM has three states: IDLE, BUS, DONE.
- IDLE, req_valid=1, legal request:
  - Latch the request.
  - Drive bus_req=1, bus_we, bus_addr, bus_be and bus_wdata from the next edge.
  - Next state is BUS.
- IDLE, req_valid=1, illegal funct3 (011, 110, 111, or 100/101 with req_we=1):
  - No bus access.
  - Next state is DONE with rsp_err=1.
- BUS:
  - Hold all bus outputs stable.
  - Timeout counter increments each cycle.
  - bus_ready=1: deassert bus_req at the edge. For a load, capture the extended bus_rdata into rsp_rdata. Next state is DONE.
  - Counter reaches TIMEOUT_CYCLES (non-zero) with no ready: deassert bus_req, rsp_err=1, rsp_rdata=0, next state is DONE.
  - bus_ready on the timeout cycle wins; no error is raised.
- DONE:
  - rsp_valid=1 for exactly one cycle, then IDLE.
  - rsp_valid, rsp_rdata and rsp_err clear on the following edge.
  - req_valid is not sampled in DONE, giving one bubble cycle between accesses.
- Stall: lsu_busy = (IDLE & req_valid) | BUS. req_valid is ignored outside IDLE.
- Minimum latency: request accepted at edge T, bus_req high T..T+1. With bus_ready at the first BUS cycle, rsp_valid is high in cycle T+2.
- Store lanes and enables (a = addr[1:0]):
  - SB (000): bus_be = 1<<a; wdata = {4{byte}}.
  - SH (001): bus_be = a[1] ? 1100 : 0011; wdata = {2{half}}.
  - SW (010): bus_be = 1111; wdata = word.
- Load lanes and extension (lane selected by a):
  - LB/LBU select byte a; LH/LHU select half a[1]; LW takes the full word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Loads drive bus_be=1111.
- Misaligned access: LH/LHU/SH with a[0]=1, or LW/SW with a!=00. Handling depends on the macro below.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: a misaligned request skips the bus and goes IDLE->DONE with rsp_err=1, rsp_rdata=0, and bus_req never rises.
- Undefined: the low offending address bits are forced to zero (half: a[0]=0; word: a=00), the access proceeds normally, and rsp_err stays 0 for misalignment.

Test Plan:
- Store byte: SB, addr=0x0000_1003, wdata=0x0000_00A5, bus_ready high the first BUS cycle -> bus_addr=0x0000_1000, bus_be=1000, bus_wdata=0xA5A5A5A5, bus_we=1; rsp_valid 2 cycles after accept, rsp_rdata=0.
- Sign-extended load: LB addr=0x2002, bus_rdata=0x12_80_34_56 -> rsp_rdata=0xFFFFFF80. Repeat as LBU -> 0x00000080. Repeat as LHU addr=0x2002 -> 0x00001280.
- Wait states: LW addr=0x3000, bus_ready held low 5 cycles then high with bus_rdata=0xDEADBEEF -> lsu_busy high throughout, bus outputs stable, rsp_valid one pulse with 0xDEADBEEF, rsp_err=0.
- Timeout: TIMEOUT_CYCLES=4, bus_ready never asserted -> bus_req high exactly 4 cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Misalignment: SW addr=0x4002. With LSU_MISALIGN_TRAP_EN -> no bus_req, rsp_err=1. Without it -> bus_addr=0x4000, bus_be=1111, rsp_err=0.
- Reset mid-op: rst=0 while in BUS -> next edge bus_req=0, rsp_valid=0, state IDLE. After release, a fresh LW completes normally; an illegal funct3=011 gives rsp_err=1 with no bus activity.
